// File: rtl/chan_packet_fir_coeff_stage_if.sv
// Register-word input and FIR tap outputs for the b20/b21 coefficient stage.
// The master drives the register word and frame sync; the slave returns the active taps and status.
interface chan_packet_fir_coeff_stage_if;
    logic [31:0] reg_data;
    logic        sync_in;
    logic [15:0] coeff_b20;
    logic [15:0] coeff_b21;
    logic        coeff_valid;
    logic        update_pulse;
    logic        pending;
    logic        sync_missing;
    logic [15:0] update_count;

    modport master (
        output reg_data, sync_in,
        input  coeff_b20, coeff_b21, coeff_valid, update_pulse,
               pending, sync_missing, update_count
    );

    modport slave (
        input  reg_data, sync_in,
        output coeff_b20, coeff_b21, coeff_valid, update_pulse,
               pending, sync_missing, update_count
    );
endinterface

// File: rtl/chan_packet_fir_coeff_stage.sv
// Accepts the FIR_b20b21 register word once it has been stable, then swaps both taps together
// on the next frame sync, or on a timeout if sync never arrives.
module chan_packet_fir_coeff_stage #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_TIMEOUT  = 65535
) (
    input  logic                          user_clk,
    input  logic                          user_rst,
    chan_packet_fir_coeff_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2
    } state_e;

    localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(SYNC_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] active_q, active_d;
    logic [31:0] cand_q, cand_d;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        valid_q, valid_d;
    logic        pulse_q, pulse_d;
    logic        pending_q;
    logic        missing_q, missing_d;
    logic [15:0] count_q, count_d;
    logic        commit;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        to_cnt_d   = to_cnt_q;
        missing_d  = missing_q;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!valid_q || (bus.reg_data != active_q)) begin
                    cand_d     = bus.reg_data;
                    stab_cnt_d = 8'd0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.reg_data != cand_q) begin
                    cand_d     = bus.reg_data;
                    stab_cnt_d = 8'd0;
                end else if (valid_q && (cand_q == active_q)) begin
                    // Software wrote back the value already in use: nothing to commit.
                    state_d = IDLE;
                end else if (stab_cnt_q == STAB_LAST) begin
                    to_cnt_d = 16'd0;
                    state_d  = ARMED;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            ARMED: begin
                // A word change outranks a coincident sync so a half-written word is never committed.
                if (bus.reg_data != cand_q) begin
                    cand_d     = bus.reg_data;
                    stab_cnt_d = 8'd0;
                    state_d    = SETTLE;
                end else if (bus.sync_in) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    commit    = 1'b1;
                    missing_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = active_q;
        valid_d  = valid_q;
        count_d  = count_q;
        pulse_d  = commit;
        if (commit) begin
            active_d = cand_q;
            valid_d  = 1'b1;
            count_d  = count_q + 16'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= IDLE;
            active_q   <= 32'd0;
            cand_q     <= 32'd0;
            stab_cnt_q <= 8'd0;
            to_cnt_q   <= 16'd0;
            valid_q    <= 1'b0;
            pulse_q    <= 1'b0;
            pending_q  <= 1'b0;
            missing_q  <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            pulse_q    <= pulse_d;
            pending_q  <= (state_d != IDLE);
            missing_q  <= missing_d;
            count_q    <= count_d;
        end
    end

    assign bus.coeff_b20    = active_q[31:16];
    assign bus.coeff_b21    = active_q[15:0];
    assign bus.coeff_valid  = valid_q;
    assign bus.update_pulse = pulse_q;
    assign bus.pending      = pending_q;
    assign bus.sync_missing = missing_q;
    assign bus.update_count = count_q;

endmodule

// File: tb/tb_chan_packet_fir_coeff_stage.sv
// Bench for chan_packet_fir_coeff_stage: per-cycle vector tables plus hand-written corner sequences,
// with every committed tap pair checked against a queue of expected commits.
module tb_chan_packet_fir_coeff_stage;

    logic user_clk = 1'b0;
    logic user_rst;

    chan_packet_fir_coeff_stage_if ifc ();

    chan_packet_fir_coeff_stage #(
        .STABLE_CYCLES (4),
        .SYNC_TIMEOUT  (8)
    ) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (ifc.slave)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [31:0] data;
        logic        sync;
        logic        commit;
        logic        exp_pending;
        logic        exp_valid;
        logic [31:0] exp_taps;
        logic        exp_pulse;
    } vec_t;

    typedef struct {
        logic [15:0] b20;
        logic [15:0] b21;
        logic [15:0] count;
        logic        missing;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_model = 16'd0;
    logic        missing_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [31:0] d, input logic s);
        ifc.reg_data = d;
        ifc.sync_in  = s;
        @(posedge user_clk);
        #1;
    endtask

    task automatic push_commit(input logic [31:0] d, input logic missing);
        exp_t e;
        cnt_model = cnt_model + 16'd1;
        e.b20     = d[31:16];
        e.b21     = d[15:0];
        e.count   = cnt_model;
        e.missing = missing;
        sb_q.push_back(e);
    endtask

    task automatic vec(input logic [31:0] d, input logic s, input logic c, input logic p,
                       input logic v, input logic [31:0] taps, input logic pu);
        vec_t r;
        r.data = d; r.sync = s; r.commit = c; r.exp_pending = p;
        r.exp_valid = v; r.exp_taps = taps; r.exp_pulse = pu;
        tbl.push_back(r);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            if (tbl[i].commit) push_commit(tbl[i].data, missing_model);
            tick(tbl[i].data, tbl[i].sync);
            chk($sformatf("%s[%0d].pending", name, i), 32'(ifc.pending), 32'(tbl[i].exp_pending));
            chk($sformatf("%s[%0d].valid", name, i), 32'(ifc.coeff_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("%s[%0d].taps", name, i), {ifc.coeff_b20, ifc.coeff_b21}, tbl[i].exp_taps);
            chk($sformatf("%s[%0d].pulse", name, i), 32'(ifc.update_pulse), 32'(tbl[i].exp_pulse));
        end
        tbl.delete();
    endtask

    // Scoreboard: every update_pulse must match the oldest expected commit.
    always @(negedge user_clk) begin
        if (ifc.update_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got taps %04h/%04h count %0d, required no commit",
                         ifc.coeff_b20, ifc.coeff_b21, ifc.update_count);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("commit.b20", 32'(ifc.coeff_b20), 32'(e.b20));
                chk("commit.b21", 32'(ifc.coeff_b21), 32'(e.b21));
                chk("commit.count", 32'(ifc.update_count), 32'(e.count));
                chk("commit.sync_missing", 32'(ifc.sync_missing), 32'(e.missing));
                $display("commit b20=%04h b21=%04h count=%0d sync_missing=%0b",
                         ifc.coeff_b20, ifc.coeff_b21, ifc.update_count, ifc.sync_missing);
            end
        end
    end

    initial begin
        ifc.reg_data = 32'd0;
        ifc.sync_in  = 1'b0;
        user_rst     = 1'b1;
        repeat (3) @(posedge user_clk);
        #1;
        chk("reset.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'd0);
        chk("reset.valid", 32'(ifc.coeff_valid), 32'd0);
        chk("reset.pulse", 32'(ifc.update_pulse), 32'd0);
        chk("reset.pending", 32'(ifc.pending), 32'd0);
        chk("reset.sync_missing", 32'(ifc.sync_missing), 32'd0);
        chk("reset.count", 32'(ifc.update_count), 32'd0);
        user_rst = 1'b0;

        // First commit; syncs during SETTLE and IDLE must be ignored.
        vec(32'h7FFF8000, 0, 0, 1, 0, 32'h0, 0);
        vec(32'h7FFF8000, 0, 0, 1, 0, 32'h0, 0);
        vec(32'h7FFF8000, 1, 0, 1, 0, 32'h0, 0);
        vec(32'h7FFF8000, 0, 0, 1, 0, 32'h0, 0);
        vec(32'h7FFF8000, 0, 0, 1, 0, 32'h0, 0);
        vec(32'h7FFF8000, 1, 1, 0, 1, 32'h7FFF8000, 1);
        vec(32'h7FFF8000, 0, 0, 0, 1, 32'h7FFF8000, 0);
        vec(32'h7FFF8000, 1, 0, 0, 1, 32'h7FFF8000, 0);
        run_table("first");
        chk("first.count", 32'(ifc.update_count), 32'd1);

        // Word changes at edge 2: stability restarts, so the sync at edge 5 is still in SETTLE.
        vec(32'h00010002, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00010002, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 1, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 0, 0, 1, 1, 32'h7FFF8000, 0);
        vec(32'h00030004, 1, 1, 0, 1, 32'h00030004, 1);
        vec(32'h00030004, 0, 0, 0, 1, 32'h00030004, 0);
        run_table("restart");
        chk("restart.count", 32'(ifc.update_count), 32'd2);

        // Word change coincident with sync while ARMED: no commit, back to SETTLE.
        repeat (5) tick(32'h11112222, 1'b0);
        tick(32'h33334444, 1'b1);
        chk("armed_change.pulse", 32'(ifc.update_pulse), 32'd0);
        chk("armed_change.pending", 32'(ifc.pending), 32'd1);
        chk("armed_change.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'h00030004);
        repeat (4) tick(32'h33334444, 1'b0);
        push_commit(32'h33334444, missing_model);
        tick(32'h33334444, 1'b1);
        chk("rearm.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'h33334444);
        chk("rearm.pending", 32'(ifc.pending), 32'd0);
        tick(32'h33334444, 1'b0);

        // Software reverts to the active word before it settles.
        tick(32'h55556666, 1'b0);
        tick(32'h33334444, 1'b0);
        tick(32'h33334444, 1'b0);
        chk("revert.pending", 32'(ifc.pending), 32'd0);
        repeat (3) begin
            tick(32'h33334444, 1'b1);
            tick(32'h33334444, 1'b0);
        end
        chk("revert.count", 32'(ifc.update_count), 32'd3);
        chk("revert.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'h33334444);

        // No sync: forced commit on the 8th ARMED cycle.
        repeat (5) tick(32'h0001FFFF, 1'b0);
        repeat (7) tick(32'h0001FFFF, 1'b0);
        chk("timeout.early_pulse", 32'(ifc.update_pulse), 32'd0);
        chk("timeout.early_pending", 32'(ifc.pending), 32'd1);
        chk("timeout.early_missing", 32'(ifc.sync_missing), 32'd0);
        missing_model = 1'b1;
        push_commit(32'h0001FFFF, missing_model);
        tick(32'h0001FFFF, 1'b0);
        chk("timeout.missing", 32'(ifc.sync_missing), 32'd1);
        chk("timeout.pending", 32'(ifc.pending), 32'd0);
        tick(32'h0001FFFF, 1'b0);

        // A normal commit afterwards leaves sync_missing set.
        repeat (5) tick(32'hFFFE0003, 1'b0);
        push_commit(32'hFFFE0003, missing_model);
        tick(32'hFFFE0003, 1'b1);
        tick(32'hFFFE0003, 1'b0);
        chk("sticky.missing", 32'(ifc.sync_missing), 32'd1);
        chk("sticky.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'hFFFE0003);

        // Reset while ARMED, with a sync on the same edge.
        repeat (5) tick(32'h12345678, 1'b0);
        user_rst = 1'b1;
        tick(32'h12345678, 1'b1);
        chk("rst.taps", {ifc.coeff_b20, ifc.coeff_b21}, 32'd0);
        chk("rst.valid", 32'(ifc.coeff_valid), 32'd0);
        chk("rst.pulse", 32'(ifc.update_pulse), 32'd0);
        chk("rst.pending", 32'(ifc.pending), 32'd0);
        chk("rst.missing", 32'(ifc.sync_missing), 32'd0);
        chk("rst.count", 32'(ifc.update_count), 32'd0);
        user_rst      = 1'b0;
        cnt_model     = 16'd0;
        missing_model = 1'b0;
        tick(32'h12345678, 1'b0);
        chk("post_rst.pending", 32'(ifc.pending), 32'd1);
        chk("post_rst.valid", 32'(ifc.coeff_valid), 32'd0);
        repeat (4) tick(32'h12345678, 1'b0);
        push_commit(32'h12345678, missing_model);
        tick(32'h12345678, 1'b1);
        tick(32'h12345678, 1'b0);
        chk("post_rst.count", 32'(ifc.update_count), 32'd1);
        chk("post_rst.valid2", 32'(ifc.coeff_valid), 32'd1);

        repeat (2) tick(32'h12345678, 1'b0);
        chk("scoreboard.drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_packet_fir_coeff_stage.md
# chan_packet_fir_coeff_stage

Downstream consumer of the `FIR_b20b21` software register in `chan_packet`, in the `user_clk` domain. It takes the 32-bit register word, requires it to be stable before accepting it, and unpacks it into FIR taps b20/b21. The new taps are committed atomically on the next frame `sync_in`, so the FIR never runs a frame with one old and one new coefficient. A timeout fallback commits the taps if sync never arrives.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a word is accepted; range 1..255.
- `SYNC_TIMEOUT`, 65535: cycles spent in ARMED without `sync_in` before a forced commit; range 1..65535.
- `user_clk` in 1: single clock for all logic.
- `user_rst` in 1: reset; synchronous, active-high.
- `reg_data` in 32: register word; [31:16] = b20, [15:0] = b21, both signed two's complement.
- `sync_in` in 1: frame-start pulse, one cycle wide.
- `coeff_b20` out 16: active b20 tap.
- `coeff_b21` out 16: active b21 tap.
- `coeff_valid` out 1: high once at least one commit has occurred since reset.
- `update_pulse` out 1: one-cycle strobe, aligned with the first cycle the new taps appear.
- `pending` out 1: high while in SETTLE or ARMED.
- `sync_missing` out 1: sticky; set by a timeout commit; cleared only by reset.
- `update_count` out 16: number of commits; wraps 65535 -> 0.

## Operation
- Registers:
  - `active[31:0]`: drives the tap outputs.
  - `cand[31:0]`: candidate word.
  - `stab_cnt[7:0]`: stability counter.
  - `to_cnt[15:0]`: timeout counter.
  - FSM state.
- Reset values:
  - `active` = 0, `cand` = 0, so `coeff_b20` = `coeff_b21` = 0.
  - `coeff_valid` = 0, `update_pulse` = 0, `pending` = 0, `sync_missing` = 0, `update_count` = 0.
  - State = IDLE.
- IDLE:
  - If `!coeff_valid` or `reg_data != active`: `cand` <= `reg_data`, `stab_cnt` <= 0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - `reg_data != cand`: `cand` <= `reg_data`, `stab_cnt` <= 0, stay in SETTLE (restart).
  - Else if `coeff_valid` and `cand == active`: go to IDLE with no commit (software reverted the write).
  - Else if `stab_cnt == STABLE_CYCLES-1`: `to_cnt` <= 0, go to ARMED.
  - Else `stab_cnt`++.
- ARMED, evaluated in priority order:
  1. `reg_data != cand`: `cand` <= `reg_data`, `stab_cnt` <= 0, go to SETTLE. This takes priority over a simultaneous `sync_in`, and no commit happens.
  2. `sync_in`: commit, go to IDLE.
  3. `to_cnt == SYNC_TIMEOUT-1`: commit, set `sync_missing`, go to IDLE.
  4. Otherwise `to_cnt`++.
- Commit, registered: `active` <= `cand`, `coeff_valid` <= 1, `update_pulse` <= 1 for one cycle, `update_count`++ (modulo 2^16).
- `sync_in` outside ARMED is ignored.
- `pending` is a registered decode of the state.
- Reset asserted mid-operation discards `cand` and returns every output to its reset value on the next edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Let a new word be present on `reg_data` at edge 0 while in IDLE:
  - SETTLE occupies edges 1..`STABLE_CYCLES`.
  - ARMED starts at edge `STABLE_CYCLES`+1.
  - `pending` is high from edge 1.
- `sync_in` sampled high in ARMED at edge N: new `coeff_*`, `update_pulse` = 1, `update_count`+1 and `pending` = 0 are all visible after edge N, i.e. in cycle N+1.
- Minimum change-to-commit latency is `STABLE_CYCLES`+2 edges. With the default of 4, a change at edge 0 and sync at edge 5 puts the new taps on the outputs after edge 5.
- Timeout: a forced commit occurs on the `SYNC_TIMEOUT`-th ARMED cycle with no `sync_in`.
- Back-to-back: after a commit, IDLE detects a further change on the next edge.

## Test plan
- Reset, then hold `reg_data` = 0x7FFF8000 and pulse `sync_in` every 16 cycles:
  - Before the first commit: `coeff_valid` = 0 and both taps read 0.
  - After the first commit: b20 = 0x7FFF, b21 = 0x8000, `update_count` = 1, `update_pulse` high for exactly one cycle.
- Write 0x00010002, then at edge 2 change to 0x00030004, then hold:
  - The stability count restarts at the change.
  - Only 0x0003/0x0004 is ever committed.
  - `update_count` increments by exactly 1.
- In ARMED, change `reg_data` in the same cycle `sync_in` is high:
  - No commit happens; the FSM returns to SETTLE.
  - The next `sync_in` after re-arming commits the new word.
- Commit a word A, change to B, then restore A within `STABLE_CYCLES`:
  - The FSM returns to IDLE.
  - `update_pulse` never fires and `update_count` is unchanged.
- Set `SYNC_TIMEOUT` = 8, change the word, and never assert `sync_in`:
  - The commit occurs on the 8th ARMED cycle.
  - `sync_missing` = 1 and stays high through later normal commits until reset.
- Assert `user_rst` for one cycle while ARMED:
  - All outputs return to their reset values on the next cycle.
  - No `update_pulse` is emitted.
  - A fresh settle begins after reset is released.
